mem_io_responder: RTL and testbench

//  Memory-side responder for the cpu byte bus (mem_a/mem_dout/mem_wr in, mem_din out).

---
 rtl/mem_io_responder.sv | 137 +++++++++++++
 tb/tb_mem_io_responder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Memory-side responder: 128KB byte RAM, UART TX/RX FIFOs, cycle counter and stop port on an I/O window.
// Define MEMIO_ADDR_CHECK_EN to flag and suppress out-of-range accesses on addr_err.
module mem_io_responder #(
    parameter int RAM_ADDR_W  = 17,
    parameter int TX_DEPTH_W  = 4,
    parameter int RX_DEPTH_W  = 3,
    parameter int FULL_MARGIN = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_stop,
    output logic        tx_overflow,
    output logic        addr_err
);
    localparam int TX_DEPTH = 1 << TX_DEPTH_W;
    localparam int RX_DEPTH = 1 << RX_DEPTH_W;
    localparam logic [TX_DEPTH_W:0] TX_FULL_LVL = (TX_DEPTH_W+1)'(TX_DEPTH);
    localparam logic [TX_DEPTH_W:0] TX_NEAR_LVL = (TX_DEPTH_W+1)'(TX_DEPTH - FULL_MARGIN);
    localparam logic [RX_DEPTH_W:0] RX_FULL_LVL = (RX_DEPTH_W+1)'(RX_DEPTH);

    logic [7:0] ram    [0:(1<<RAM_ADDR_W)-1];
    logic [7:0] tx_mem [0:TX_DEPTH-1];
    logic [7:0] rx_mem [0:RX_DEPTH-1];

    logic [TX_DEPTH_W:0]   tx_wr_ptr, tx_rd_ptr, tx_count, tx_count_nxt;
    logic [RX_DEPTH_W:0]   rx_wr_ptr, rx_rd_ptr, rx_count;
    logic [31:0]           counter, snapshot;
    logic                  io, addr_bad, acc, tx_full, rx_empty;
    logic                  ram_we, tx_req, tx_push, tx_pop, rx_push, rx_pop;
    logic [15:0]           io_off;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic [7:0]            tx_wdat, rd_dat;

    assign io      = (mem_a[17:16] == 2'b11);
    assign io_off  = mem_a[15:0];
    assign ram_idx = mem_a[RAM_ADDR_W-1:0];

`ifdef MEMIO_ADDR_CHECK_EN
    assign addr_bad = io ? (mem_a[31:18] != '0) : (mem_a[31:RAM_ADDR_W] != '0);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)                   addr_err <= 1'b0;
        else if (rdy_in && addr_bad)  addr_err <= 1'b1;
    end
`else
    logic unused_upper;
    assign unused_upper = ^mem_a[31:18];
    assign addr_bad     = 1'b0;
    assign addr_err     = 1'b0;
`endif

    // cpu-side effects only happen on ready cycles with a legal address
    assign acc     = rdy_in && !addr_bad;
    assign ram_we  = acc && mem_wr && !io;
    assign tx_req  = acc && mem_wr && io &&
                     (((io_off == 16'h0000) && (mem_dout != 8'h00)) || (io_off == 16'h0004));
    assign tx_wdat = (io_off == 16'h0004) ? 8'h00 : mem_dout;

    assign tx_count     = tx_wr_ptr - tx_rd_ptr;
    assign tx_full      = (tx_count == TX_FULL_LVL);
    assign tx_valid     = (tx_count != '0);
    assign tx_pop       = tx_valid && tx_ready;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign tx_push      = tx_req && (!tx_full || tx_pop);
    assign tx_count_nxt = tx_count + {{TX_DEPTH_W{1'b0}}, tx_push} - {{TX_DEPTH_W{1'b0}}, tx_pop};
    assign tx_data      = tx_mem[tx_rd_ptr[TX_DEPTH_W-1:0]];

    assign rx_count = rx_wr_ptr - rx_rd_ptr;
    assign rx_empty = (rx_count == '0);
    assign rx_ready = (rx_count != RX_FULL_LVL);
    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = acc && !mem_wr && io && (io_off == 16'h0000) && !rx_empty;

    always_comb begin
        rd_dat = 8'h00;
        if (!io) begin
            rd_dat = ram[ram_idx];
        end else begin
            case (io_off)
                16'h0000: rd_dat = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr[RX_DEPTH_W-1:0]];
                16'h0004: rd_dat = counter[7:0];
                16'h0005: rd_dat = snapshot[15:8];
                16'h0006: rd_dat = snapshot[23:16];
                16'h0007: rd_dat = snapshot[31:24];
                default:  rd_dat = 8'h00;
            endcase
        end
        if (addr_bad) rd_dat = 8'h00;
    end

    always_ff @(posedge clk_in) begin
        if (ram_we)  ram[ram_idx] <= mem_dout;
        if (tx_push) tx_mem[tx_wr_ptr[TX_DEPTH_W-1:0]] <= tx_wdat;
        if (rx_push) rx_mem[rx_wr_ptr[RX_DEPTH_W-1:0]] <= rx_data;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tx_wr_ptr      <= '0;
            tx_rd_ptr      <= '0;
            rx_wr_ptr      <= '0;
            rx_rd_ptr      <= '0;
            counter        <= '0;
            snapshot       <= '0;
            mem_din        <= 8'h00;
            io_buffer_full <= 1'b0;
            tx_overflow    <= 1'b0;
            program_stop   <= 1'b0;
        end else begin
            counter <= counter + 32'd1;
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + (TX_DEPTH_W+1)'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + (TX_DEPTH_W+1)'(1);
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + (RX_DEPTH_W+1)'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + (RX_DEPTH_W+1)'(1);
            io_buffer_full <= (tx_count_nxt >= TX_NEAR_LVL);
            if (tx_req && !tx_push) tx_overflow <= 1'b1;
            if (acc && mem_wr && io && (io_off == 16'h0004)) program_stop <= 1'b1;
            if (rdy_in && !mem_wr) begin
                mem_din <= rd_dat;
                // freeze the whole dword so the upper bytes read back coherently
                if (acc && io && (io_off == 16'h0004)) snapshot <= counter;
            end
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed vector table, corner-case sequences, randomized run vs queue model.
module tb_mem_io_responder;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic [31:0] mem_a = 32'h0003_0002;
    logic [7:0]  mem_dout = 8'h00;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        program_stop, tx_overflow, addr_err;

    localparam logic [31:0] IDLE_A = 32'h0003_0002;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] cyc;
    logic [7:0]  tx_seen[$];

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
        .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .program_stop(program_stop), .tx_overflow(tx_overflow), .addr_err(addr_err)
    );

    always #5 clk_in = ~clk_in;

    // elapsed clocks since reset release, i.e. the expected cycle-counter value
    always @(posedge clk_in or posedge rst_in)
        if (rst_in) cyc <= 32'd0;
        else        cyc <= cyc + 32'd1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        if (tx_valid && tx_ready) tx_seen.push_back(tx_data);
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input bit rdy, input bit wr, input logic [31:0] a, input logic [7:0] d);
        rdy_in = rdy; mem_wr = wr; mem_a = a; mem_dout = d;
    endtask

    task automatic do_reset(input bit chk);
        rst_in = 1'b1;
        drive(1'b1, 1'b0, IDLE_A, 8'h00);
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        tick(); tick();
        if (chk) begin
            check("reset mem_din", mem_din, 8'h00);
            check("reset tx_valid", tx_valid, 1'b0);
            check("reset rx_ready", rx_ready, 1'b1);
            check("reset io_buffer_full", io_buffer_full, 1'b0);
            check("reset program_stop", program_stop, 1'b0);
            check("reset tx_overflow", tx_overflow, 1'b0);
            check("reset addr_err", addr_err, 1'b0);
        end
        rst_in = 1'b0;
        tx_seen.delete();
    endtask

    typedef struct {
        bit          rdy;
        bit          wr;
        logic [31:0] a;
        logic [7:0]  d;
        bit          chk;
        logic [7:0]  exp;
    } vec_t;

    task automatic run_table();
        vec_t vt[13];
        vt[0]  = '{1, 1, 32'h0000_0100, 8'hA5, 0, 8'h00};
        vt[1]  = '{1, 0, 32'h0000_0100, 8'h00, 1, 8'hA5};
        vt[2]  = '{1, 1, 32'h0001_FFFF, 8'h3C, 0, 8'h00};
        vt[3]  = '{1, 0, 32'h0001_FFFF, 8'h00, 1, 8'h3C};
        vt[4]  = '{0, 0, 32'h0000_0100, 8'h00, 1, 8'h3C};
        vt[5]  = '{0, 1, 32'h0000_0100, 8'hEE, 0, 8'h00};
        vt[6]  = '{1, 0, 32'h0000_0100, 8'h00, 1, 8'hA5};
        vt[7]  = '{1, 1, 32'h0003_0008, 8'h77, 0, 8'h00};
        vt[8]  = '{1, 0, 32'h0003_0001, 8'h00, 1, 8'h00};
        vt[9]  = '{1, 0, 32'h0003_0000, 8'h00, 1, 8'h00};
        vt[10] = '{1, 1, 32'h0002_0100, 8'h5A, 0, 8'h00};
`ifdef MEMIO_ADDR_CHECK_EN
        vt[11] = '{1, 0, 32'h0000_0100, 8'h00, 1, 8'hA5};
`else
        vt[11] = '{1, 0, 32'h0000_0100, 8'h00, 1, 8'h5A};
`endif
        vt[12] = '{1, 0, 32'h0001_FFFF, 8'h00, 1, 8'h3C};
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].rdy, vt[i].wr, vt[i].a, vt[i].d);
            tick();
            if (vt[i].chk) check($sformatf("table[%0d] mem_din", i), mem_din, vt[i].exp);
            check($sformatf("table[%0d] tx_valid", i), tx_valid, 1'b0);
        end
`ifdef MEMIO_ADDR_CHECK_EN
        check("table addr_err", addr_err, 1'b1);
`else
        check("table addr_err", addr_err, 1'b0);
`endif
        drive(1'b1, 1'b0, IDLE_A, 8'h00);
    endtask

    task automatic run_random(input int n);
        logic [7:0]  ram_m [int];
        logic [7:0]  txq[$];
        logic [7:0]  rxq[$];
        logic [7:0]  exp_din, d, pv;
        logic [31:0] snap, a;
        logic [15:0] off;
        bit          din_known, exp_ibf, exp_ovf, exp_stop;
        bit          wr, rdy, io, tx_pop, tx_req, rx_push, rx_pop;
        int          sel;
        exp_din = 8'h00; snap = 32'h0; din_known = 1;
        exp_ibf = 0; exp_ovf = 0; exp_stop = 0;
        for (int k = 0; k < n; k++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: a = 32'h0000_0200 + $urandom_range(0, 7);
                4, 5, 9:    a = 32'h0003_0000;
                6:          a = 32'h0003_0004;
                7:          a = 32'h0003_0005 + $urandom_range(0, 2);
                default:    a = 32'h0003_0003;
            endcase
            wr  = ($urandom_range(0, 1) == 1) && !(sel == 6 && $urandom_range(0, 3) != 0);
            d   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            rdy = ($urandom_range(0, 7) != 0);
            drive(rdy, wr, a, d);
            tx_ready = ($urandom_range(0, 2) == 0);
            rx_valid = ($urandom_range(0, 1) == 1);
            rx_data  = 8'($urandom);

            check("rnd tx_valid", tx_valid, (txq.size() != 0));
            if (txq.size() != 0) check("rnd tx_data", tx_data, txq[0]);
            check("rnd rx_ready", rx_ready, (rxq.size() < 8));
            check("rnd io_buffer_full", io_buffer_full, exp_ibf);
            check("rnd tx_overflow", tx_overflow, exp_ovf);
            check("rnd program_stop", program_stop, exp_stop);
            if (din_known) check("rnd mem_din", mem_din, exp_din);

            io      = (a[17:16] == 2'b11);
            off     = a[15:0];
            tx_pop  = (txq.size() != 0) && tx_ready;
            rx_push = rx_valid && (rxq.size() < 8);
            tx_req  = 0; rx_pop = 0; pv = 8'h00;
            if (rdy && wr) begin
                if (!io) ram_m[int'(a[16:0])] = d;
                else if (off == 16'h0000 && d != 8'h00) begin tx_req = 1; pv = d; end
                else if (off == 16'h0004) begin tx_req = 1; pv = 8'h00; exp_stop = 1; end
            end else if (rdy) begin
                din_known = 1;
                if (!io) begin
                    if (ram_m.exists(int'(a[16:0]))) exp_din = ram_m[int'(a[16:0])];
                    else din_known = 0;
                end else begin
                    case (off)
                        16'h0000: begin
                            exp_din = (rxq.size() != 0) ? rxq[0] : 8'h00;
                            rx_pop  = (rxq.size() != 0);
                        end
                        16'h0004: begin exp_din = cyc[7:0]; snap = cyc; end
                        16'h0005: exp_din = 8'((snap >> 8) % 256);
                        16'h0006: exp_din = 8'((snap >> 16) % 256);
                        16'h0007: exp_din = 8'((snap >> 24) % 256);
                        default:  exp_din = 8'h00;
                    endcase
                end
            end
            if (tx_pop) void'(txq.pop_front());
            if (tx_req) begin
                if (txq.size() < 16) txq.push_back(pv);
                else exp_ovf = 1;
            end
            if (rx_pop)  void'(rxq.pop_front());
            if (rx_push) rxq.push_back(rx_data);
            exp_ibf = ((16 - txq.size()) <= 4);
            tick();
        end
        drive(1'b1, 1'b0, IDLE_A, 8'h00);
        rx_valid = 1'b0; tx_ready = 1'b0;
    endtask

    initial begin
        int guard;
        #2;
        do_reset(1'b1);
        drive(1'b1, 1'b0, 32'h0003_0004, 8'h00);
        tick();
        check("counter starts at 0", mem_din, 8'h00);
        run_table();

        // TX: zero byte written to the data port is not queued
        do_reset(1'b0);
        tx_ready = 1'b1;
        drive(1'b1, 1'b1, 32'h0003_0000, 8'h48); tick();
        drive(1'b1, 1'b1, 32'h0003_0000, 8'h00); tick();
        drive(1'b1, 1'b1, 32'h0003_0000, 8'h69); tick();
        drive(1'b1, 1'b0, IDLE_A, 8'h00);
        for (int i = 0; i < 6; i++) tick();
        check("tx stream length", tx_seen.size(), 2);
        if (tx_seen.size() == 2) begin
            check("tx stream byte0", tx_seen[0], 8'h48);
            check("tx stream byte1", tx_seen[1], 8'h69);
        end

        // TX fill: near-full flag after 12, overflow on the 17th
        do_reset(1'b0);
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, 1'b1, 32'h0003_0000, 8'(i));
            tick();
            if (i == 11) check("ibf after 11", io_buffer_full, 1'b0);
            if (i == 12) check("ibf after 12", io_buffer_full, 1'b1);
            if (i == 16) check("no overflow at 16", tx_overflow, 1'b0);
        end
        check("overflow after 17", tx_overflow, 1'b1);
        drive(1'b1, 1'b0, IDLE_A, 8'h00);
        tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("drain count", tx_seen.size(), 16);
        if (tx_seen.size() == 16) begin
            check("drain first", tx_seen[0], 8'h01);
            check("drain last", tx_seen[15], 8'h10);
        end
        check("ibf after drain", io_buffer_full, 1'b0);

        // counter snapshot coherence
        do_reset(1'b0);
        guard = 0;
        while (cyc != 32'h1FF && guard < 2000) begin tick(); guard++; end
        check("counter wait in budget", (guard < 2000), 1'b1);
        drive(1'b1, 1'b0, 32'h0003_0004, 8'h00); tick();
        check("counter byte0", mem_din, 8'hFF);
        drive(1'b1, 1'b0, IDLE_A, 8'h00); tick(); tick();
        drive(1'b1, 1'b0, 32'h0003_0005, 8'h00); tick();
        check("snapshot byte1", mem_din, 8'h01);
        drive(1'b1, 1'b0, 32'h0003_0007, 8'h00); tick();
        check("snapshot byte3", mem_din, 8'h00);

        // RX reads, stall hold, empty read
        do_reset(1'b0);
        drive(1'b1, 1'b0, IDLE_A, 8'h00);
        rx_valid = 1'b1; rx_data = 8'h31; tick();
        rx_data = 8'h32; tick();
        rx_valid = 1'b0;
        drive(1'b1, 1'b0, 32'h0003_0000, 8'h00); tick();
        check("rx read 1", mem_din, 8'h31);
        drive(1'b0, 1'b0, 32'h0003_0000, 8'h00); tick();
        check("rx stalled hold", mem_din, 8'h31);
        drive(1'b1, 1'b0, 32'h0003_0000, 8'h00); tick();
        check("rx read 2", mem_din, 8'h32);
        tick();
        check("rx read empty", mem_din, 8'h00);

        // RX full: 9th byte refused
        drive(1'b1, 1'b0, IDLE_A, 8'h00);
        rx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rx_data = 8'h40 + 8'(i);
            tick();
            if (i == 6) check("rx_ready at 7", rx_ready, 1'b1);
        end
        check("rx_ready full", rx_ready, 1'b0);
        rx_valid = 1'b0;
        drive(1'b1, 1'b0, 32'h0003_0000, 8'h00);
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("rx drain %0d", i), mem_din, (i < 8) ? 8'h40 + 8'(i) : 8'h00);
        end

        // program stop then asynchronous reset mid-transfer
        do_reset(1'b0);
        drive(1'b1, 1'b1, 32'h0003_0004, 8'h99); tick();
        check("program_stop set", program_stop, 1'b1);
        check("stop byte valid", tx_valid, 1'b1);
        check("stop byte value", tx_data, 8'h00);
        drive(1'b1, 1'b0, IDLE_A, 8'h00);
        #2 rst_in = 1'b1;
        #1;
        check("async rst tx_valid", tx_valid, 1'b0);
        check("async rst program_stop", program_stop, 1'b0);
        tick();
        rst_in = 1'b0;

        do_reset(1'b0);
        run_random(700);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
